// File: rtl/racetrack_shift_ctrl.sv
// Racetrack shift controller: sequences set shifts toward the access port and
// reset shifts back to home, one current pulse per domain step.
module racetrack_shift_ctrl #(
    parameter int CNT_WIDTH    = 10,
    parameter int N_DOMAINS    = 512,
    parameter int PULSE_CYCLES = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 shift_en_s_i,
    input  logic                 shift_en_r_i,
    input  logic                 source_shift_sel_i,
    input  logic [CNT_WIDTH-1:0] n_shift_i,
    output logic                 shift_done_s_o,
    output logic                 shift_done_r_o,
    output logic                 shift_pulse_o,
    output logic                 shift_dir_o,
    output logic [CNT_WIDTH-1:0] track_pos_o,
    output logic                 protocol_err_o
);

    localparam int PH_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(N_DOMAINS);
    localparam logic [PH_W-1:0]      LAST_PH = PH_W'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SHIFT_SET, DONE_SET, SHIFT_RESET, DONE_RESET
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] step_q, step_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [CNT_WIDTH-1:0] n_q, n_d;
    logic [CNT_WIDTH-1:0] pos_q, pos_d;
    logic                 pulse, err, dir;
    logic [CNT_WIDTH-1:0] set_cnt, rst_cnt;

    function automatic logic [CNT_WIDTH-1:0] clamp_cnt(input logic [CNT_WIDTH-1:0] n);
        return (n > MAX_CNT) ? MAX_CNT : n;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            step_q  <= '0;
            phase_q <= '0;
            n_q     <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            n_q     <= n_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        phase_d = phase_q;
        n_d     = n_q;
        pos_d   = pos_q;
        pulse   = 1'b0;
        err     = 1'b0;
        dir     = 1'b1;
        set_cnt = clamp_cnt(n_shift_i);
        rst_cnt = clamp_cnt(source_shift_sel_i ? n_q : n_shift_i);

        case (state_q)
            IDLE: begin
                if (shift_en_s_i) begin
                    err     = shift_en_r_i;
                    step_d  = set_cnt;
                    n_d     = set_cnt;
                    phase_d = '0;
                    state_d = (set_cnt != '0) ? SHIFT_SET : DONE_SET;
                end else if (shift_en_r_i) begin
                    step_d  = rst_cnt;
                    phase_d = '0;
                    state_d = (rst_cnt != '0) ? SHIFT_RESET : DONE_RESET;
                end
            end
            SHIFT_SET, SHIFT_RESET: begin
                dir   = (state_q == SHIFT_SET);
                err   = dir ? shift_en_r_i : shift_en_s_i;
                pulse = (phase_q == '0);
                if (pulse) begin
                    if (dir) begin
                        if (pos_q < MAX_CNT) pos_d = pos_q + CNT_WIDTH'(1);
                    end else if (pos_q == '0) begin
                        // Shifting right past home is a request error; the track stays put.
                        err = 1'b1;
                    end else begin
                        pos_d = pos_q - CNT_WIDTH'(1);
                    end
                end
                if (phase_q == LAST_PH) begin
                    phase_d = '0;
                    step_d  = step_q - CNT_WIDTH'(1);
                    if (step_q <= CNT_WIDTH'(1))
                        state_d = dir ? DONE_SET : DONE_RESET;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            DONE_SET: begin
                err = shift_en_r_i;
                if (!shift_en_s_i) state_d = IDLE;
            end
            DONE_RESET: begin
                dir = 1'b0;
                err = shift_en_s_i;
                if (!shift_en_r_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pulse and error are suppressed in a reset cycle so no current flows mid-reset.
    assign shift_pulse_o  = pulse & ~rst_i;
    assign protocol_err_o = err & ~rst_i;
    assign shift_dir_o    = dir;
    assign shift_done_s_o = (state_q == DONE_SET);
    assign shift_done_r_o = (state_q == DONE_RESET);
    assign track_pos_o    = pos_q;

endmodule

// File: tb/tb_racetrack_shift_ctrl.sv
// Directed bench for racetrack_shift_ctrl: per-cycle vector table plus
// multi-cycle sequences for count clamping, saturation and PULSE_CYCLES=3.
module tb_racetrack_shift_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, s_a, r_a, sel_a, s_b, r_b, sel_b;
    logic [9:0] n_a, n_b;
    logic       ds_a, dr_a, p_a, d_a, e_a;
    logic       ds_b, dr_b, p_b, d_b, e_b;
    logic [9:0] pos_a, pos_b;

    racetrack_shift_ctrl #(.CNT_WIDTH(10), .N_DOMAINS(512), .PULSE_CYCLES(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .shift_en_s_i(s_a), .shift_en_r_i(r_a),
        .source_shift_sel_i(sel_a), .n_shift_i(n_a),
        .shift_done_s_o(ds_a), .shift_done_r_o(dr_a), .shift_pulse_o(p_a),
        .shift_dir_o(d_a), .track_pos_o(pos_a), .protocol_err_o(e_a)
    );

    racetrack_shift_ctrl #(.CNT_WIDTH(10), .N_DOMAINS(512), .PULSE_CYCLES(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .shift_en_s_i(s_b), .shift_en_r_i(r_b),
        .source_shift_sel_i(sel_b), .n_shift_i(n_b),
        .shift_done_s_o(ds_b), .shift_done_r_o(dr_b), .shift_pulse_o(p_b),
        .shift_dir_o(d_b), .track_pos_o(pos_b), .protocol_err_o(e_b)
    );

    typedef struct packed {
        logic       rst, s, r, sel;
        logic [9:0] n;
        logic       p, d, ds, dr;
        logic [9:0] pos;
        logic       e;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        int pcnt;
        int first_done;
        logic [10:0] pmask;
        logic done_seen;

        rst = 1'b1; s_a = 0; r_a = 0; sel_a = 0; n_a = '0;
        s_b = 0; r_b = 0; sel_b = 0; n_b = '0;

        //           rst s r sel n    p d ds dr pos e
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd0, 1'b0,1'b1,1'b0,1'b0,10'd0,1'b0}); // 0 reset state
        tbl.push_back({1'b0,1'b1,1'b0,1'b0,10'd3, 1'b0,1'b1,1'b0,1'b0,10'd0,1'b0}); // 1 set n=3, cycle 0
        tbl.push_back({1'b0,1'b1,1'b0,1'b0,10'd3, 1'b1,1'b1,1'b0,1'b0,10'd0,1'b0}); // 2 pulse 1
        tbl.push_back({1'b0,1'b1,1'b0,1'b0,10'd3, 1'b1,1'b1,1'b0,1'b0,10'd1,1'b0}); // 3 pulse 2
        tbl.push_back({1'b0,1'b1,1'b0,1'b0,10'd3, 1'b1,1'b1,1'b0,1'b0,10'd2,1'b0}); // 4 pulse 3
        tbl.push_back({1'b0,1'b1,1'b0,1'b0,10'd3, 1'b0,1'b1,1'b1,1'b0,10'd3,1'b0}); // 5 done_s
        tbl.push_back({1'b0,1'b1,1'b1,1'b0,10'd3, 1'b0,1'b1,1'b1,1'b0,10'd3,1'b1}); // 6 reset req in DONE_SET
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd3, 1'b0,1'b1,1'b1,1'b0,10'd3,1'b0}); // 7 drop s
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd3, 1'b0,1'b1,1'b0,1'b0,10'd3,1'b0}); // 8 idle
        tbl.push_back({1'b0,1'b0,1'b1,1'b1,10'd7, 1'b0,1'b1,1'b0,1'b0,10'd3,1'b0}); // 9 reset from n_q
        tbl.push_back({1'b0,1'b0,1'b1,1'b1,10'd7, 1'b1,1'b0,1'b0,1'b0,10'd3,1'b0}); // 10
        tbl.push_back({1'b0,1'b1,1'b1,1'b1,10'd7, 1'b1,1'b0,1'b0,1'b0,10'd2,1'b1}); // 11 set req in reset
        tbl.push_back({1'b0,1'b0,1'b1,1'b1,10'd7, 1'b1,1'b0,1'b0,1'b0,10'd1,1'b0}); // 12
        tbl.push_back({1'b0,1'b0,1'b0,1'b1,10'd7, 1'b0,1'b0,1'b0,1'b1,10'd0,1'b0}); // 13 done_r
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd0, 1'b0,1'b1,1'b0,1'b0,10'd0,1'b0}); // 14 idle
        tbl.push_back({1'b0,1'b1,1'b1,1'b0,10'd2, 1'b0,1'b1,1'b0,1'b0,10'd0,1'b1}); // 15 both enables
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd2, 1'b1,1'b1,1'b0,1'b0,10'd0,1'b0}); // 16 s dropped mid-shift
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd2, 1'b1,1'b1,1'b0,1'b0,10'd1,1'b0}); // 17
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd2, 1'b0,1'b1,1'b1,1'b0,10'd2,1'b0}); // 18 done for one cycle
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd2, 1'b0,1'b1,1'b0,1'b0,10'd2,1'b0}); // 19
        tbl.push_back({1'b0,1'b1,1'b0,1'b0,10'd0, 1'b0,1'b1,1'b0,1'b0,10'd2,1'b0}); // 20 zero-count set
        tbl.push_back({1'b0,1'b1,1'b0,1'b0,10'd0, 1'b0,1'b1,1'b1,1'b0,10'd2,1'b0}); // 21 done at cycle 1
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd0, 1'b0,1'b1,1'b1,1'b0,10'd2,1'b0}); // 22
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd0, 1'b0,1'b1,1'b0,1'b0,10'd2,1'b0}); // 23
        tbl.push_back({1'b0,1'b0,1'b1,1'b0,10'd5, 1'b0,1'b1,1'b0,1'b0,10'd2,1'b0}); // 24 reset n=5 from pos 2
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd5, 1'b1,1'b0,1'b0,1'b0,10'd2,1'b0}); // 25
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd5, 1'b1,1'b0,1'b0,1'b0,10'd1,1'b0}); // 26
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd5, 1'b1,1'b0,1'b0,1'b0,10'd0,1'b1}); // 27 underflow
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd5, 1'b1,1'b0,1'b0,1'b0,10'd0,1'b1}); // 28 underflow
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd5, 1'b1,1'b0,1'b0,1'b0,10'd0,1'b1}); // 29 underflow
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd5, 1'b0,1'b0,1'b0,1'b1,10'd0,1'b0}); // 30 done_r
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd0, 1'b0,1'b1,1'b0,1'b0,10'd0,1'b0}); // 31
        tbl.push_back({1'b0,1'b1,1'b0,1'b0,10'd5, 1'b0,1'b1,1'b0,1'b0,10'd0,1'b0}); // 32 set n=5
        tbl.push_back({1'b0,1'b1,1'b0,1'b0,10'd5, 1'b1,1'b1,1'b0,1'b0,10'd0,1'b0}); // 33
        tbl.push_back({1'b0,1'b1,1'b0,1'b0,10'd5, 1'b1,1'b1,1'b0,1'b0,10'd1,1'b0}); // 34
        tbl.push_back({1'b1,1'b1,1'b0,1'b0,10'd5, 1'b0,1'b1,1'b0,1'b0,10'd2,1'b0}); // 35 rst mid-shift
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd5, 1'b0,1'b1,1'b0,1'b0,10'd0,1'b0}); // 36 reset values
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd5, 1'b0,1'b1,1'b0,1'b0,10'd0,1'b0}); // 37
        tbl.push_back({1'b0,1'b0,1'b1,1'b1,10'd9, 1'b0,1'b1,1'b0,1'b0,10'd0,1'b0}); // 38 n_q cleared by rst
        tbl.push_back({1'b0,1'b0,1'b1,1'b1,10'd9, 1'b0,1'b0,1'b0,1'b1,10'd0,1'b0}); // 39 done_r holds
        tbl.push_back({1'b0,1'b0,1'b0,1'b1,10'd9, 1'b0,1'b0,1'b0,1'b1,10'd0,1'b0}); // 40
        tbl.push_back({1'b0,1'b0,1'b0,1'b0,10'd0, 1'b0,1'b1,1'b0,1'b0,10'd0,1'b0}); // 41

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; s_a = tbl[i].s; r_a = tbl[i].r;
            sel_a = tbl[i].sel; n_a = tbl[i].n;
            #1;
            n_vec++;
            if ({p_a, d_a, ds_a, dr_a, pos_a, e_a} !==
                {tbl[i].p, tbl[i].d, tbl[i].ds, tbl[i].dr, tbl[i].pos, tbl[i].e}) begin
                n_bad++;
                $display("FAIL vec%0d: got p=%b d=%b ds=%b dr=%b pos=%0d err=%b, want p=%b d=%b ds=%b dr=%b pos=%0d err=%b",
                         i, p_a, d_a, ds_a, dr_a, pos_a, e_a,
                         tbl[i].p, tbl[i].d, tbl[i].ds, tbl[i].dr, tbl[i].pos, tbl[i].e);
            end
        end

        // Oversized request is clamped to N_DOMAINS steps.
        @(negedge clk);
        rst = 1'b0; s_a = 1'b1; r_a = 1'b0; sel_a = 1'b0; n_a = 10'd517;
        pcnt = 0; done_seen = 1'b0;
        for (int k = 0; k < 600 && !done_seen; k++) begin
            @(negedge clk); #1;
            if (p_a) pcnt++;
            if (ds_a) done_seen = 1'b1;
        end
        check("clamp_done_seen", int'(done_seen), 1);
        check("clamp_pulses", pcnt, 512);
        check("clamp_pos", int'(pos_a), 512);

        // Further set pulses must not move the track past N_DOMAINS.
        @(negedge clk); s_a = 1'b0;
        @(negedge clk); s_a = 1'b1; n_a = 10'd3;
        pcnt = 0; done_seen = 1'b0;
        for (int k = 0; k < 20 && !done_seen; k++) begin
            @(negedge clk); #1;
            if (p_a) pcnt++;
            if (ds_a) done_seen = 1'b1;
        end
        check("sat_done_seen", int'(done_seen), 1);
        check("sat_pulses", pcnt, 3);
        check("sat_pos", int'(pos_a), 512);
        @(negedge clk); s_a = 1'b0;

        // PULSE_CYCLES=3, n=2: pulses on cycles 1 and 4, done on cycle 7.
        @(negedge clk);
        s_b = 1'b1; n_b = 10'd2;
        pmask = '0; first_done = -1;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            pmask[k] = p_b;
            if (ds_b && first_done < 0) first_done = k;
        end
        check("pc3_pulse_mask", int'(pmask), int'(11'b000_0001_0010));
        check("pc3_done_cycle", first_done, 7);
        check("pc3_pos", int'(pos_b), 2);
        check("pc3_dir", int'(d_b), 1);
        @(negedge clk); s_b = 1'b0;
        @(negedge clk); #1;
        check("pc3_idle_done", int'(ds_b), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/racetrack_shift_ctrl.md
RACETRACK_SHIFT_CTRL -- requirements
Module: racetrack_shift_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 10, width of shift-count inputs and counters.
REQ-002 SHALL have parameter N_DOMAINS, default 512, maximum legal shift count per access.
REQ-003 SHALL have parameter PULSE_CYCLES, default 1, cycles per shift step (>=1).
REQ-004 SHALL have port clk_i  input  1  single clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port shift_en_s_i  input  1  request set shift (toward access port), from port controller.
REQ-007 SHALL have port shift_en_r_i  input  1  request reset shift (return to home position).
REQ-008 SHALL have port source_shift_sel_i  input  1  reset count source: 1 = sampled set count, 0 = n_shift_i.
REQ-009 SHALL have port n_shift_i  input  CNT_WIDTH  requested shift count, derived from address.
REQ-010 SHALL have port shift_done_s_o  output  1  set shift complete.
REQ-011 SHALL have port shift_done_r_o  output  1  reset shift complete.
REQ-012 SHALL have port shift_pulse_o  output  1  one-cycle current pulse to racetrack shifter, one per step.
REQ-013 SHALL have port shift_dir_o  output  1  direction: 1 = set/left, 0 = reset/right.
REQ-014 SHALL have port track_pos_o  output  CNT_WIDTH  current domain offset from home.
REQ-015 SHALL have port protocol_err_o  output  1  one-cycle flag for illegal request combination.

Function
REQ-016 SHALL implement states IDLE, SHIFT_SET, DONE_SET, SHIFT_RESET, DONE_RESET.
REQ-017 In IDLE with shift_en_s_i=1: latch cnt = min(n_shift_i, N_DOMAINS) into step counter and n_q; go SHIFT_SET if cnt!=0, else DONE_SET.
REQ-018 In IDLE with shift_en_r_i=1 and shift_en_s_i=0: load cnt = min(source_shift_sel_i ? n_q : n_shift_i, N_DOMAINS); go SHIFT_RESET if cnt!=0, else DONE_RESET.
REQ-019 Both enables high in IDLE: set has priority; protocol_err_o=1 for that cycle.
REQ-020 In SHIFT_* states each step lasts PULSE_CYCLES cycles; shift_pulse_o=1 on first cycle of each step only.
REQ-021 shift_dir_o=1 in SHIFT_SET/DONE_SET, 0 in SHIFT_RESET/DONE_RESET, 1 in IDLE.
REQ-022 track_pos_o increments on each set pulse, decrements on each reset pulse; saturates at N_DOMAINS and 0.
REQ-023 A reset pulse with track_pos_o=0 SHALL not decrement and SHALL raise protocol_err_o that cycle.
REQ-024 After last cycle of last step, go DONE_SET/DONE_RESET; SHIFT_* lasts exactly cnt*PULSE_CYCLES cycles.
REQ-025 shift_done_s_o=1 exactly while in DONE_SET; shift_done_r_o=1 exactly while in DONE_RESET (registered, no combinational path from inputs).
REQ-026 DONE_SET stays while shift_en_s_i=1; on 0 go IDLE. DONE_RESET likewise with shift_en_r_i.
REQ-027 Enable dropped during SHIFT_* SHALL not abort: steps complete, then DONE_* for at least one cycle, then IDLE.
REQ-028 shift_en_r_i=1 in SHIFT_SET/DONE_SET (or shift_en_s_i=1 in reset states) SHALL raise protocol_err_o and be ignored.
REQ-029 n_q SHALL hold its value until next set load; counters CNT_WIDTH wide, no wrap.

Reset
REQ-030 rst_i=1 at a clock edge SHALL force IDLE, counters/n_q/track_pos_o=0, all done/pulse/err outputs 0, shift_dir_o=1, from any state, including mid-shift; no pulse in that cycle or the next.

Verification
REQ-031 PULSE_CYCLES=1, n_shift_i=3, shift_en_s_i held from cycle 0 -> pulses cycles 1,2,3, dir=1, shift_done_s_o from cycle 4, track_pos_o=3.
REQ-032 After REQ-031, shift_en_r_i with source_shift_sel_i=1, n_shift_i=7 -> exactly 3 pulses dir=0, shift_done_r_o, track_pos_o=0.
REQ-033 n_shift_i=0 set -> no pulses, shift_done_s_o cycle 1; PULSE_CYCLES=3, n=2 -> pulses cycles 1,4, done cycle 7.
REQ-034 n_shift_i=N_DOMAINS+5 -> exactly N_DOMAINS pulses, track_pos_o=N_DOMAINS.
REQ-035 shift_en_s_i and shift_en_r_i both high in IDLE -> set sequence runs, protocol_err_o pulse cycle 0.
REQ-036 rst_i asserted during SHIFT_SET after 2 of 5 pulses -> IDLE, track_pos_o=0, no further pulses, outputs at reset values.
